// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// START/BUSY/DONE handshake and operand/result bus for the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: a - b - bin = diff - 2*bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single subtractor cell.
//   state   | meaning
//   IDLE    | waiting for start; outputs hold last result
//   SHIFT   | one operand bit per clock through the cell
//   DONE_ST | one-cycle completion pulse, busy still high
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_ff;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             cell_diff;
    logic             cell_bout;
    logic             last;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_ff),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE_ST;
            DONE_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr      <= bus.a;
                        b_sr      <= bus.b;
                        res_sr    <= '0;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                    end
                end
                SHIFT: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    res_sr    <= {cell_diff, res_sr[WIDTH-1:1]};
                    borrow_ff <= cell_bout;
                    cnt       <= cnt + CW'(1);
                    // Publish only the complete word so diff never shows partial bits
                    if (last) begin
                        diff_q   <= {cell_diff, res_sr[WIDTH-1:1]};
                        borrow_q <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == SHIFT) || (state == DONE_ST);
    assign bus.done   = (state == DONE_ST);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
